// File: rtl/rr_distr_lock_if.sv
// Stream bundle for rr_distr_lock: one producer-side stream in, NumOut consumer-side streams out.
// Signal names are from the distributor's point of view; the producer/consumer bench side uses the master modport.
interface rr_distr_lock_if #(
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32
);
    logic                                req_i;
    logic                                gnt_o;
    logic [DataWidth-1:0]                data_i;
    logic [NumOut-1:0]                   req_o;
    logic [NumOut-1:0]                   gnt_i;
    logic [NumOut-1:0][DataWidth-1:0]    data_o;

    modport master (
        output req_i, data_i, gnt_i,
        input  gnt_o, req_o, data_o
    );

    modport slave (
        input  req_i, data_i, gnt_i,
        output gnt_o, req_o, data_o
    );
endinterface

// File: rtl/rr_distr_lock.sv
// Round-robin stream distributor with pointer hold, flush and selection lock-in.
// Optional macro RR_DISTR_ASSERT_EN compiles in protocol assertions.
module rr_distr_lock #(
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AxiVldRdy = 1,
    parameter int unsigned LockIn    = 1,
    localparam int unsigned IdxWidth = (NumOut > 1) ? $clog2(NumOut) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                lock_rr_i,
    rr_distr_lock_if.slave      dist_if,
    output logic [IdxWidth-1:0] idx_o
);
    localparam bit                  LockEn  = (AxiVldRdy == 0) && (LockIn != 0);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumOut - 1);

    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [IdxWidth-1:0] sel_q, sel_d;
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] sel, sel_scan, k_idx;
    logic                scan_hit;
    logic                hs;

    // Non-AXI mode: first granting output at or after the pointer, circularly.
    always_comb begin
        sel_scan = rr_q;
        scan_hit = 1'b0;
        k_idx    = '0;
        for (int unsigned o = 0; o < NumOut; o++) begin
            int unsigned k;
            k = 32'(rr_q) + o;
            if (k >= NumOut) begin
                k = k - NumOut;
            end
            k_idx = IdxWidth'(k);
            if (!scan_hit && dist_if.gnt_i[k_idx]) begin
                sel_scan = k_idx;
                scan_hit = 1'b1;
            end
        end
    end

    always_comb begin
        if (AxiVldRdy != 0) begin
            sel = rr_q;
        end else if (LockEn && lock_q) begin
            sel = sel_q;
        end else begin
            sel = sel_scan;
        end
    end

    always_comb begin
        dist_if.req_o      = '0;
        dist_if.req_o[sel] = dist_if.req_i;
    end

    assign dist_if.gnt_o  = dist_if.gnt_i[sel];
    assign dist_if.data_o = {NumOut{dist_if.data_i}};
    assign idx_o          = sel;
    assign hs             = dist_if.req_i & dist_if.gnt_o;

    always_comb begin
        rr_d   = rr_q;
        lock_d = lock_q;
        sel_d  = sel_q;
        if (flush_i) begin
            rr_d   = '0;
            lock_d = 1'b0;
            sel_d  = '0;
        end else if (hs) begin
            if (!lock_rr_i) begin
                rr_d = (sel == LastIdx) ? '0 : sel + 1'b1;
            end
            lock_d = 1'b0;
        end else if (LockEn && dist_if.req_i) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            sel_q  <= sel_d;
        end
    end

`ifdef RR_DISTR_ASSERT_EN
    if (NumOut < 1) begin : g_numout_chk
        $error("rr_distr_lock: NumOut must be at least 1");
    end

    a_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(dist_if.req_o));

    a_req_sel: assert property (@(posedge clk_i) disable iff (rst_i)
        dist_if.req_o[idx_o] == dist_if.req_i);

    a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        dist_if.req_i && !dist_if.gnt_o |=> dist_if.req_i && $stable(dist_if.data_i));

    // Only AXI mode and lock-in mode promise a fixed target while stalled.
    if ((AxiVldRdy != 0) || (LockIn != 0)) begin : g_stable_chk
        a_idx_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
            dist_if.req_i && !dist_if.gnt_o |=> $stable(idx_o));
    end
`endif
endmodule
